// File: rtl/stream_mux_nx1_rr.sv
// stream_mux_nx1_rr
// Registered N-input stream multiplexer with per-channel valid/ready handshake.
// It selects one producer channel, either the fixed channel named by sel or
// the next valid channel in round-robin order. The chosen word goes into a
// single output register that drives one consumer.
//
// Parameters
//   WIDTH     data bits per channel (>= 1)
//   CHANNELS  number of input channels (>= 2)
//   SEL_W     channel-index width, 2**SEL_W >= CHANNELS
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_data       channel k data at [k*WIDTH +: WIDTH]
//   in_valid      per-channel valid
//   in_ready      per-channel ready, one-hot or zero
//   mode          0 = fixed select via sel, 1 = round-robin
//   sel           channel index used in fixed mode
//   out_data      registered output data
//   out_chan      channel that supplied out_data
//   out_valid     output register holds a word
//   out_ready     consumer accepts out_data
//
// Optional feature (macro STREAM_MUX_XFER_CNT_EN)
//   xfer_cnt_clr  synchronous clear of xfer_cnt, wins over an increment
//   xfer_cnt      16-bit wrapping count of completed output transfers

module stream_mux_nx1_rr #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef STREAM_MUX_XFER_CNT_EN
    ,
    input  logic                      xfer_cnt_clr,
    output logic [15:0]               xfer_cnt
`endif
);

    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   chan_q;
    logic [SEL_W-1:0]   last_q;

    logic               fix_gnt;
    logic [SEL_W-1:0]   fix_idx;
    logic               rr_gnt;
    logic [SEL_W-1:0]   rr_idx;
    logic               gnt;
    logic [SEL_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]   gnt_data;
    logic               can_load;
    logic               load;

    // Fixed mode: out-of-range sel matches no channel, so no grant is made.
    always_comb begin
        fix_gnt = 1'b0;
        fix_idx = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
                fix_gnt = 1'b1;
                fix_idx = SEL_W'(k);
            end
        end
    end

    // Round-robin: scan channels above last first, then wrap to 0..last.
    // Scanning in two ascending passes avoids a modulo on the index.
    always_comb begin
        rr_gnt = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!rr_gnt && in_valid[k] && (SEL_W'(k) > last_q)) begin
                rr_gnt = 1'b1;
                rr_idx = SEL_W'(k);
            end
        end
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!rr_gnt && in_valid[k] && (SEL_W'(k) <= last_q)) begin
                rr_gnt = 1'b1;
                rr_idx = SEL_W'(k);
            end
        end
    end

    always_comb begin
        gnt     = mode ? rr_gnt : fix_gnt;
        gnt_idx = mode ? rr_idx : fix_idx;
    end

    // The register can take a word when it is empty or when it is draining
    // in this same cycle. Gating with rst keeps in_ready low during reset.
    always_comb begin
        can_load = (state_q == StEmpty) || out_ready;
        load     = gnt && can_load && !rst;
    end

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                in_ready[k] = load;
                gnt_data    = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register FSM. A drain without a refill leaves data and channel
    // as they were, so only out_valid changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= SEL_W'(CHANNELS - 1);
        end else begin
            case (state_q)
                StEmpty: begin
                    if (load) begin
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (out_ready && !load) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
            if (load) begin
                data_q <= gnt_data;
                chan_q <= gnt_idx;
                // Fixed-mode loads leave the round-robin pointer alone.
                if (mode) begin
                    last_q <= gnt_idx;
                end
            end
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

`ifdef STREAM_MUX_XFER_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (xfer_cnt_clr) begin
            xfer_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_nx1_rr.sv
// Directed, table-driven bench for stream_mux_nx1_rr with WIDTH=2, CHANNELS=4
// and SEL_W=3. The wider select lets the bench drive an out-of-range index.
module tb_stream_mux_nx1_rr;

    localparam int unsigned WIDTH    = 2;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned SEL_W    = 3;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;
`ifdef STREAM_MUX_XFER_CNT_EN
    logic                      xfer_cnt_clr;
    logic [15:0]               xfer_cnt;
`endif

    stream_mux_nx1_rr #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .SEL_W   (SEL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .sel         (sel),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_valid   (out_valid),
`ifdef STREAM_MUX_XFER_CNT_EN
        .xfer_cnt_clr(xfer_cnt_clr),
        .xfer_cnt    (xfer_cnt),
`endif
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [3:0] valid;
        logic [7:0] data;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_od;
        logic [2:0] exp_oc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Channel data: ch0=01, ch1=10, ch2=11, ch3=00.
    localparam logic [7:0] DataA = 8'b00_11_10_01;
    localparam logic [7:0] DataB = 8'b11_00_01_10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic m, input logic [2:0] s, input logic [3:0] v,
                       input logic [7:0] d, input logic r, input logic [3:0] er,
                       input logic eov, input logic [1:0] eod, input logic [2:0] eoc);
        vec_t t;
        t.mode = m; t.sel = s; t.valid = v; t.data = d; t.ordy = r;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_oc = eoc;
        vecs.push_back(t);
    endtask

    initial begin
        //  mode sel valid    data   ordy rdy      ov  od     oc
        // Fixed select of channel 2.
        add(1'b0, 3'd2, 4'b1111, DataA, 1'b1, 4'b0100, 1'b1, 2'b11, 3'd2);
        // Round-robin fairness, pointer still at 3 after the fixed load.
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b0001, 1'b1, 2'b01, 3'd0);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b0010, 1'b1, 2'b10, 3'd1);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b0100, 1'b1, 2'b11, 3'd2);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b1000, 1'b1, 2'b00, 3'd3);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b0001, 1'b1, 2'b01, 3'd0);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b0010, 1'b1, 2'b10, 3'd1);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b0100, 1'b1, 2'b11, 3'd2);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b1, 4'b1000, 1'b1, 2'b00, 3'd3);
        // Sparse round-robin: 0 first (last=3), then 3, 0, 3.
        add(1'b1, 3'd0, 4'b1001, DataA, 1'b1, 4'b0001, 1'b1, 2'b01, 3'd0);
        add(1'b1, 3'd0, 4'b1001, DataA, 1'b1, 4'b1000, 1'b1, 2'b00, 3'd3);
        add(1'b1, 3'd0, 4'b1001, DataA, 1'b1, 4'b0001, 1'b1, 2'b01, 3'd0);
        add(1'b1, 3'd0, 4'b1001, DataA, 1'b1, 4'b1000, 1'b1, 2'b00, 3'd3);
        // Out-of-range sel: no grant, drain to empty, data and chan held.
        add(1'b0, 3'd5, 4'b1111, DataA, 1'b1, 4'b0000, 1'b0, 2'b00, 3'd3);
        add(1'b0, 3'd5, 4'b1111, DataA, 1'b1, 4'b0000, 1'b0, 2'b00, 3'd3);
        // Backpressure: load ch1 into the empty register, then stall for 3 cycles.
        add(1'b0, 3'd1, 4'b1111, DataA, 1'b0, 4'b0010, 1'b1, 2'b10, 3'd1);
        add(1'b0, 3'd1, 4'b1111, DataB, 1'b0, 4'b0000, 1'b1, 2'b10, 3'd1);
        add(1'b0, 3'd2, 4'b0110, DataB, 1'b0, 4'b0000, 1'b1, 2'b10, 3'd1);
        add(1'b1, 3'd0, 4'b1111, DataA, 1'b0, 4'b0000, 1'b1, 2'b10, 3'd1);
        // Release: drain and load in the same cycle.
        add(1'b0, 3'd2, 4'b1111, DataA, 1'b1, 4'b0100, 1'b1, 2'b11, 3'd2);
        // Selected channel not valid.
        add(1'b0, 3'd0, 4'b1110, DataA, 1'b1, 4'b0000, 1'b0, 2'b11, 3'd2);
        // Round-robin pointer untouched by fixed loads (still 3).
        add(1'b1, 3'd0, 4'b0100, DataA, 1'b1, 4'b0100, 1'b1, 2'b11, 3'd2);
        add(1'b1, 3'd0, 4'b0000, DataA, 1'b1, 4'b0000, 1'b0, 2'b11, 3'd2);

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
`ifdef STREAM_MUX_XFER_CNT_EN
        xfer_cnt_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_chan", 32'(out_chan), 32'd0);
`ifdef STREAM_MUX_XFER_CNT_EN
        check("reset xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].valid;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
            check($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(vecs[i].exp_oc));
        end

        // Mid-stream reset: load ch3 (pointer at 2), then assert rst between edges.
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = DataA;
        out_ready = 1'b0;
        #1;
        check("pre-rst in_ready", 32'(in_ready), 32'b1000);
        @(posedge clk);
        #1;
        check("pre-rst out_valid", 32'(out_valid), 32'd1);
        check("pre-rst out_chan", 32'(out_chan), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rst async out_valid", 32'(out_valid), 32'd0);
        check("rst async out_data", 32'(out_data), 32'd0);
        check("rst async out_chan", 32'(out_chan), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst held in_ready", 32'(in_ready), 32'd0);
        check("rst held out_valid", 32'(out_valid), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("post-rst out_valid", 32'(out_valid), 32'd1);
        check("post-rst out_chan", 32'(out_chan), 32'd0);
        check("post-rst out_data", 32'(out_data), 32'b01);

`ifdef STREAM_MUX_XFER_CNT_EN
        // Clear during a transfer wins over the increment.
        in_valid     = 4'b0000;
        xfer_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        check("cnt clr", 32'(xfer_cnt), 32'd0);
        check("cnt clr drain", 32'(out_valid), 32'd0);
        xfer_cnt_clr = 1'b0;
        in_valid     = 4'b1111;
        // First edge loads the empty register, next ten each complete a transfer.
        repeat (11) @(posedge clk);
        #1;
        check("cnt ten", 32'(xfer_cnt), 32'd10);
        xfer_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        check("cnt clr xfer", 32'(xfer_cnt), 32'd0);
        xfer_cnt_clr = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_nx1_rr.md
Name: stream_mux_nx1_rr

Overview:
- Registered N-input, W-bit stream multiplexer with per-channel valid/ready handshake.
- Next generation of the team's 4x1 2-bit select mux: generalised in width and channel count, with an output register and two selection modes.
  - Fixed-select mode behaves like the existing combinational mux.
  - Round-robin mode arbitrates among valid channels.
- Sits between multiple producer streams and a single consumer.

Parameters:
- WIDTH, 2, data bits per channel (>=1).
- CHANNELS, 4, number of input channels (>=2).
- SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready; at most one bit high per cycle.
- mode  in  1  0 = fixed select via sel, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  WIDTH  registered output data.
- out_chan  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset is asynchronous and active-high.
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer last=CHANNELS-1, so channel 0 has first priority.
- Output register has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- load = (EMPTY or (FULL and out_ready)) and a grant exists.
- Fixed mode (mode=0):
  - Grant channel sel iff sel<CHANNELS and in_valid[sel]=1.
  - sel>=CHANNELS means no grant, and no in_ready bit is asserted.
- RR mode (mode=1):
  - Grant the first k with in_valid[k]=1, scanning (last+1)..(last+CHANNELS) mod CHANNELS.
  - On load, last <= granted index.
  - Fixed-mode loads never update last.
- in_ready[g] = 1 only for the granted channel g, and only when load can occur.
  - in_ready is combinational from in_valid, mode, sel, out_valid, out_ready and last.
  - A transfer on channel g occurs when in_valid[g] & in_ready[g].
- Latency: input accepted at edge t appears on out_data/out_chan/out_valid after edge t, i.e. 1 cycle.
- Throughput: one transfer per cycle when out_ready is held high (simultaneous drain and load).
- Backpressure: while FULL and out_ready=0, out_data/out_chan are held stable and all in_ready=0.
- Transitions:
  - FULL with out_ready=1 and no grant -> EMPTY; out_data keeps its last value.
  - EMPTY with no grant stays EMPTY.
- A change of mode or sel takes effect on the next grant evaluation. Data already registered is unaffected.
- Reset asserted mid-transfer discards the registered word immediately; no in_ready is asserted while rst=1.
- RR wrap: after granting CHANNELS-1, channel 0 has highest priority.
- With all channels valid continuously, RR grants 0,1,...,CHANNELS-1,0,...

Optional Feature:
- Macro: STREAM_MUX_XFER_CNT_EN.
- Defined:
  - Adds port xfer_cnt (out, 16 bits): count of completed output transfers (out_valid & out_ready).
  - Reset to 0; wraps 16'hFFFF -> 0.
  - Adds port xfer_cnt_clr (in, 1): synchronous clear.
  - Clear has priority over a same-cycle increment, so the result is 0.
- Undefined: neither port exists; the rest of the behaviour is identical.

Test Plan:
- Reset: drive rst=1 mid-stream, then release -> out_valid=0, out_data=0, out_chan=0, all in_ready=0 during reset; first RR grant goes to channel 0.
- Fixed mode, WIDTH=2, CHANNELS=4: in_data channels {A=2'b01, B=2'b10, C=2'b11, D=2'b00}, all valid, sel=2, out_ready=1 -> in_ready=4'b0100, next cycle out_data=2'b11, out_chan=2.
- RR fairness: all in_valid=1, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Backpressure: FULL with out_chan=1, out_ready=0 for 3 cycles while inputs change -> out_data/out_chan stable, in_ready=0; out_ready=1 -> next word loads the same cycle.
- Sparse RR with out_ready=1:
  - in_valid=4'b1001 with last=0 -> grant 3, then 0, then 3.
  - Then sel=5 with CHANNELS=4 and mode=0 -> no grant; out_valid falls to 0 after the drain.
- With STREAM_MUX_XFER_CNT_EN: 10 transfers -> xfer_cnt=10; pulse xfer_cnt_clr during a transfer -> xfer_cnt=0 next cycle.
